mole_pos_gen: RTL and testbench
===============================

# mole_pos_gen

Parametrised pseudo-random mole-position generator for the whack-a-mole game. A free-running Galois LFSR supplies entropy. A request/valid handshake returns a position uniformly drawn from 0..NUM_HOLES-1 by rejection sampling, with an optional no-repeat mode so the same hole is never lit twice in a row. It sits between the game-control FSM (issues `req`) and the hole/LED driver (consumes `pos`). It replaces the fixed 5-bit count-up generator.

## Interface
Parameters:
- WIDTH, 16 — LFSR width; 4..32.
- TAPS, 16'hB400 — Galois feedback mask, WIDTH bits; must be maximal-length.
- SEED, 16'hACE1 — reset/default seed; nonzero.
- NUM_HOLES, 9 — number of positions; 2..2**POS_W, with NUM_HOLES <= 2**WIDTH.
- MAX_TRIES, 8 — rejected draws before fallback; >= 1.
- POS_W, $clog2(NUM_HOLES) — derived; not overridden.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- seed_load  in  1  load `seed_in` into the LFSR this cycle.
- seed_in  in  WIDTH  seed value; 0 is replaced by SEED.
- no_repeat  in  1  mode; sampled at `req` acceptance.
- req  in  1  request a new position; accepted only when `busy`=0.
- busy  out  1  draw in progress.
- pos  out  POS_W  last delivered position; held between draws.
- pos_valid  out  1  one-cycle pulse, `pos` updated this cycle.
- fallback  out  1  one-cycle pulse with `pos_valid` when the fallback path produced `pos`.

## Operation
- LFSR advances every cycle, including IDLE and DRAW, so draw results depend on request timing.
- Galois step: `lfsr <= (lfsr >> 1) ^ (lfsr[0] ? TAPS : 0)`.
- `seed_load` overrides the step for that cycle and has priority over the step in any state. A draw in progress continues on the reloaded value.
- FSM states:
  - IDLE: `busy`=0. On `req`, latch `no_repeat` into `nr_q`, clear `tries`, and go to DRAW.
  - DRAW: `busy`=1. The candidate is `lfsr[POS_W-1:0]`, using the register value at this edge. The candidate is rejected if `cand >= NUM_HOLES` or (`nr_q` && `have_last` && `cand == pos`).
    - Accept: `pos <= cand`, assert `pos_valid`, set `have_last`, and go to IDLE.
    - Reject: `tries++`.
    - Forced result: when `tries == MAX_TRIES-1` and the candidate is still rejected, `pos <= (have_last ? (pos+1) mod NUM_HOLES : 0)`, assert `pos_valid` and `fallback`, and go to IDLE.
- `req` while `busy`=1 is ignored; it is not queued.
- `have_last` is cleared only by reset. The first draw after reset can never be a no-repeat reject.
- Arithmetic: the modulo wrap is a compare-and-clear (`pos == NUM_HOLES-1` → 0), not a divider.

## Timing
- Reset values: `lfsr`=SEED, state=IDLE, `busy`=0, `pos`=0, `pos_valid`=0, `fallback`=0, `have_last`=0, `tries`=0.
- Reset mid-draw: the draw is abandoned with no `pos_valid`.
- Latency, counted from the edge that samples `req`:
  - `busy` is high from the next cycle.
  - Best case: `pos_valid` is high 2 cycles after `req` (1 DRAW cycle).
  - Worst case: MAX_TRIES+1 cycles.
- `busy` falls in the same cycle that `pos_valid` pulses. A new `req` may be sampled in that cycle's following edge.
- All outputs are registered; no combinational input→output paths.

## Structure
- Shared package `mole_pkg`:
  - default NUM_HOLES;
  - maximal-length TAPS constants for WIDTH 4/5/8/16/32;
  - FSM state enum `gen_state_t` (IDLE, DRAW).
- Sub-module `lfsr_core` (WIDTH, TAPS, SEED; ports clk, rst_n, load, load_val, q). It handles zero-seed substitution internally.
- `mole_pos_gen` holds the FSM, the rejection logic and the fallback logic.

## Test plan
- Reset and seed: reset, then `seed_load`=1 with `seed_in`=0 → the next-cycle LFSR equals SEED (16'hACE1), `pos`=0, `busy`=0. Free-run 65535 cycles → the LFSR returns to SEED with no all-zero state.
- Full range: NUM_HOLES=16, no_repeat=0, pulse `req` → `pos_valid` exactly 2 cycles later, with `pos` equal to the LFSR low 4 bits at the DRAW edge. Then issue 10k requests → every value 0..15 appears, each within ±10% of 625.
- Rejection: NUM_HOLES=9 → `pos` never exceeds 8 over 10k draws. Latency never exceeds MAX_TRIES+1 cycles.
- No-repeat: no_repeat=1, 5k back-to-back requests → no two consecutive `pos` values are equal. With no_repeat=0, repeats do occur.
- Fallback: NUM_HOLES=9 and MAX_TRIES=1. Force `lfsr` low bits to 4'hF via seed_in=16'h000F with `pos`=8 → `pos`=0 and `fallback`=1. With `have_last`=0 → `pos`=0.
- Boundary events:
  - `req` while `busy` → ignored; exactly one `pos_valid`.
  - `seed_load` during DRAW → the draw completes using the new seed.
  - `rst_n`=0 mid-DRAW → no `pos_valid`, and all outputs return to reset values the next cycle.

Source files
------------

// File: rtl/mole_pkg.sv
// Shared definitions for the whack-a-mole position generator: default hole
// count, maximal-length Galois feedback masks and the generator FSM states.
package mole_pkg;

    // Default number of holes on the board.
    localparam int unsigned DEF_NUM_HOLES = 9;

    // Maximal-length masks for a right-shifting Galois LFSR.
    // Bit (n-1) of each mask corresponds to polynomial term x^n.
    localparam logic [3:0]  TAPS_W4  = 4'hC;          // x^4 + x^3 + 1
    localparam logic [4:0]  TAPS_W5  = 5'h14;         // x^5 + x^3 + 1
    localparam logic [7:0]  TAPS_W8  = 8'hB8;         // x^8 + x^6 + x^5 + x^4 + 1
    localparam logic [15:0] TAPS_W16 = 16'hB400;      // x^16 + x^14 + x^13 + x^11 + 1
    localparam logic [31:0] TAPS_W32 = 32'h8020_0003; // x^32 + x^22 + x^2 + x + 1

    // Generator FSM: waiting for a request, or drawing candidates.
    typedef enum logic {
        IDLE = 1'b0,
        DRAW = 1'b1
    } gen_state_t;

endpackage

// File: rtl/mole_pos_gen_lfsr_core.sv
// Free-running Galois LFSR with a synchronous seed load. A zero seed would
// lock the register up, so it is silently replaced by the default SEED.
module lfsr_core
    import mole_pkg::*;
#(
    parameter int unsigned       WIDTH = 16,
    parameter logic [WIDTH-1:0]  TAPS  = TAPS_W16,
    parameter logic [WIDTH-1:0]  SEED  = 16'hACE1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_lfsr;
    logic [WIDTH-1:0] w_seed;
    logic [WIDTH-1:0] w_step;

    assign w_seed = (load_val == '0) ? SEED : load_val;
    assign w_step = (r_lfsr >> 1) ^ (r_lfsr[0] ? TAPS : '0);

    // Register update: reset to SEED, a load overrides the step, else step.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            r_lfsr <= SEED;
        end else if (load) begin
            r_lfsr <= w_seed;
        end else begin
            r_lfsr <= w_step;
        end
    end

    assign q = r_lfsr;

endmodule

// File: rtl/mole_pos_gen.sv
// Mole position generator. On an accepted request it draws candidates from
// the low bits of a free-running LFSR until one lands on a valid hole (and,
// in no-repeat mode, differs from the last delivered hole). After MAX_TRIES
// rejected candidates it falls back to the next hole in sequence.
module mole_pos_gen
    import mole_pkg::*;
#(
    parameter int unsigned       WIDTH     = 16,
    parameter logic [WIDTH-1:0]  TAPS      = TAPS_W16,
    parameter logic [WIDTH-1:0]  SEED      = 16'hACE1,
    parameter int unsigned       NUM_HOLES = DEF_NUM_HOLES,
    parameter int unsigned       MAX_TRIES = 8,
    parameter int unsigned       POS_W     = $clog2(NUM_HOLES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed_in,
    input  logic             no_repeat,
    input  logic             req,
    output logic             busy,
    output logic [POS_W-1:0] pos,
    output logic             pos_valid,
    output logic             fallback
);

    // tries only counts 0..MAX_TRIES-1; the last value triggers the fallback.
    localparam int unsigned      TRY_W    = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
    localparam logic [TRY_W-1:0] LAST_TRY = TRY_W'(MAX_TRIES - 1);
    localparam logic [POS_W-1:0] LAST_POS = POS_W'(NUM_HOLES - 1);
    localparam logic [POS_W:0]   HOLES_X  = (POS_W + 1)'(NUM_HOLES);

    gen_state_t       r_state, w_state_nxt;
    logic [POS_W-1:0] r_pos, w_pos_nxt;
    logic [TRY_W-1:0] r_tries, w_tries_nxt;
    logic             r_nr, w_nr_nxt;
    logic             r_have_last, w_have_last_nxt;
    logic             r_valid, w_valid_nxt;
    logic             r_fallback, w_fallback_nxt;

    logic [WIDTH-1:0] w_lfsr;
    logic [POS_W-1:0] w_cand;
    logic             w_out_of_range;
    logic             w_repeat;
    logic             w_reject;
    logic [POS_W-1:0] w_wrap_pos;
    logic [POS_W-1:0] w_fb_pos;

    lfsr_core #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS),
        .SEED  (SEED)
    ) u_lfsr (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (seed_load),
        .load_val (seed_in),
        .q        (w_lfsr)
    );

    // Only the low POS_W bits feed the candidate; the rest is pure state.
    generate
        if (WIDTH > POS_W) begin : g_high_bits
            logic w_unused_high;
            assign w_unused_high = ^w_lfsr[WIDTH-1:POS_W];
        end
    endgenerate

    // Candidate from the registered LFSR value and its rejection terms.
    // The compare is one bit wider so NUM_HOLES == 2**POS_W never rejects.
    assign w_cand         = w_lfsr[POS_W-1:0];
    assign w_out_of_range = ({1'b0, w_cand} >= HOLES_X);
    assign w_repeat       = r_nr && r_have_last && (w_cand == r_pos);
    assign w_reject       = w_out_of_range || w_repeat;

    // Fallback hole: next in sequence with a compare-and-clear wrap.
    assign w_wrap_pos = (r_pos == LAST_POS) ? '0 : (r_pos + POS_W'(1));
    assign w_fb_pos   = r_have_last ? w_wrap_pos : '0;

    // Next-state and next-output decode for the draw FSM.
    always_comb begin
        // NOTE: every value gets a default first so no latch is inferred.
        w_state_nxt     = r_state;
        w_pos_nxt       = r_pos;
        w_tries_nxt     = r_tries;
        w_nr_nxt        = r_nr;
        w_have_last_nxt = r_have_last;
        w_valid_nxt     = 1'b0;
        w_fallback_nxt  = 1'b0;

        unique case (r_state)
            IDLE: begin
                if (req) begin
                    w_nr_nxt    = no_repeat;
                    w_tries_nxt = '0;
                    w_state_nxt = DRAW;
                end
            end
            DRAW: begin
                if (!w_reject) begin
                    w_pos_nxt       = w_cand;
                    w_valid_nxt     = 1'b1;
                    w_have_last_nxt = 1'b1;
                    w_state_nxt     = IDLE;
                end else if (r_tries == LAST_TRY) begin
                    w_pos_nxt      = w_fb_pos;
                    w_valid_nxt    = 1'b1;
                    w_fallback_nxt = 1'b1;
                    w_state_nxt    = IDLE;
                end else begin
                    w_tries_nxt = r_tries + TRY_W'(1);
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State and output registers; reset abandons any draw in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_pos       <= '0;
            r_tries     <= '0;
            r_nr        <= 1'b0;
            r_have_last <= 1'b0;
            r_valid     <= 1'b0;
            r_fallback  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_pos       <= w_pos_nxt;
            r_tries     <= w_tries_nxt;
            r_nr        <= w_nr_nxt;
            r_have_last <= w_have_last_nxt;
            r_valid     <= w_valid_nxt;
            r_fallback  <= w_fallback_nxt;
        end
    end

    assign busy      = (r_state == DRAW);
    assign pos       = r_pos;
    assign pos_valid = r_valid;
    assign fallback  = r_fallback;

endmodule

// File: tb/tb_mole_pos_gen.sv
// Bench for mole_pos_gen. Three instances share one clock:
//   u0: 9 holes, 8 tries   u1: 16 holes, 8 tries   u2: 9 holes, 1 try
// A reference LFSR per instance predicts every draw; predictions are queued
// when a request is driven and popped when pos_valid arrives.
module tb_mole_pos_gen;
    import mole_pkg::*;

    localparam logic [15:0] SEED = 16'hACE1;

    typedef struct {
        int pos;
        bit fb;
        int lat;
    } exp_t;

    logic        clk = 1'b0;
    logic [2:0]  rst_n;
    logic [2:0]  seed_load;
    logic [2:0]  no_repeat;
    logic [2:0]  req;
    logic [15:0] seed_in [3];
    logic [2:0]  busy;
    logic [2:0]  pos_valid;
    logic [2:0]  fallback;
    logic [3:0]  pos [3];

    logic [15:0] m_lfsr [3];
    bit          m_hl [3];
    int          m_last [3];
    exp_t        sb [$];

    int n_checks;
    int n_err;
    int p, lat, prev, reps, extra;
    logic [15:0] seen;

    always #5 clk = ~clk;

    mole_pos_gen #(.NUM_HOLES(9), .MAX_TRIES(8)) u0 (
        .clk(clk), .rst_n(rst_n[0]), .seed_load(seed_load[0]), .seed_in(seed_in[0]),
        .no_repeat(no_repeat[0]), .req(req[0]), .busy(busy[0]), .pos(pos[0]),
        .pos_valid(pos_valid[0]), .fallback(fallback[0]));

    mole_pos_gen #(.NUM_HOLES(16), .MAX_TRIES(8)) u1 (
        .clk(clk), .rst_n(rst_n[1]), .seed_load(seed_load[1]), .seed_in(seed_in[1]),
        .no_repeat(no_repeat[1]), .req(req[1]), .busy(busy[1]), .pos(pos[1]),
        .pos_valid(pos_valid[1]), .fallback(fallback[1]));

    mole_pos_gen #(.NUM_HOLES(9), .MAX_TRIES(1)) u2 (
        .clk(clk), .rst_n(rst_n[2]), .seed_load(seed_load[2]), .seed_in(seed_in[2]),
        .no_repeat(no_repeat[2]), .req(req[2]), .busy(busy[2]), .pos(pos[2]),
        .pos_valid(pos_valid[2]), .fallback(fallback[2]));

    function automatic int nh_of(input int id);
        return (id == 1) ? 16 : 9;
    endfunction

    function automatic int mt_of(input int id);
        return (id == 2) ? 1 : 8;
    endfunction

    function automatic logic [15:0] step(input logic [15:0] v);
        return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    // Reference LFSRs, one per instance.
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (!rst_n[i])         m_lfsr[i] <= SEED;
            else if (seed_load[i]) m_lfsr[i] <= (seed_in[i] == 16'h0) ? SEED : seed_in[i];
            else                   m_lfsr[i] <= step(m_lfsr[i]);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected outcome of a draw whose first DRAW edge sees LFSR value v1.
    function automatic exp_t predict(input int id, input logic [15:0] v1, input logic nr);
        exp_t        e;
        logic [15:0] v;
        int          c;
        v = v1;
        for (int k = 1; k <= mt_of(id); k++) begin
            c = int'(v[3:0]);
            if (!(c >= nh_of(id) || (nr && m_hl[id] && c == m_last[id]))) begin
                e.pos = c;
                e.fb  = 1'b0;
                e.lat = k + 1;
                return e;
            end
            v = step(v);
        end
        e.fb  = 1'b1;
        e.lat = mt_of(id) + 1;
        e.pos = m_hl[id] ? ((m_last[id] == nh_of(id) - 1) ? 0 : m_last[id] + 1) : 0;
        return e;
    endfunction

    // Drive a request (optionally with a seed load on the same edge).
    task automatic start_req(input int id, input logic nr, input logic ld,
                             input logic [15:0] ldv, input bit push);
        logic [15:0] v1;
        v1 = ld ? ((ldv == 16'h0) ? SEED : ldv) : step(m_lfsr[id]);
        if (push) sb.push_back(predict(id, v1, nr));
        req[id]       = 1'b1;
        no_repeat[id] = nr;
        seed_load[id] = ld;
        seed_in[id]   = ldv;
    endtask

    // Wait (bounded) for pos_valid, then compare against the queued prediction.
    task automatic wait_result(input int id, input logic again, input logic mid_ld,
                               input logic [15:0] mid_val, output int got_pos, output int got_lat);
        int   cnt;
        exp_t e;
        @(negedge clk);
        cnt           = 1;
        req[id]       = again;
        seed_load[id] = mid_ld;
        seed_in[id]   = mid_val;
        check($sformatf("busy_next[%0d]", id), busy[id], 1);
        while (!pos_valid[id] && cnt < mt_of(id) + 4) begin
            @(negedge clk);
            cnt++;
            req[id]       = 1'b0;
            seed_load[id] = 1'b0;
        end
        req[id]       = 1'b0;
        seed_load[id] = 1'b0;
        got_pos = int'(pos[id]);
        got_lat = cnt;
        check($sformatf("pos_valid_seen[%0d]", id), pos_valid[id], 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check($sformatf("pos[%0d]", id), pos[id], e.pos);
            check($sformatf("fallback[%0d]", id), fallback[id], e.fb);
            check($sformatf("latency[%0d]", id), cnt, e.lat);
            check($sformatf("busy_fall[%0d]", id), busy[id], 0);
            m_last[id] = e.pos;
            if (!e.fb) m_hl[id] = 1'b1;
        end
    endtask

    initial begin
        n_checks  = 0;
        n_err     = 0;
        rst_n     = '0;
        seed_load = '0;
        no_repeat = '0;
        req       = '0;
        for (int i = 0; i < 3; i++) begin
            seed_in[i] = 16'h0;
            m_hl[i]    = 1'b0;
            m_last[i]  = 0;
        end
        repeat (3) @(negedge clk);

        // Reset values.
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rst_busy[%0d]", i), busy[i], 0);
            check($sformatf("rst_pos[%0d]", i), pos[i], 0);
            check($sformatf("rst_pos_valid[%0d]", i), pos_valid[i], 0);
            check($sformatf("rst_fallback[%0d]", i), fallback[i], 0);
        end
        check("rst_lfsr", u0.u_lfsr.q, SEED);
        rst_n = '1;

        // Zero seed is replaced by SEED.
        seed_load[1] = 1'b1;
        seed_in[1]   = 16'h0000;
        @(negedge clk);
        seed_load[1] = 1'b0;
        check("zero_seed_lfsr", u1.u_lfsr.q, SEED);
        check("zero_seed_pos", pos[1], 0);
        check("zero_seed_busy", busy[1], 0);

        fork
            begin : period_chk
                int early;
                bit zero_seen;
                early     = 0;
                zero_seen = 1'b0;
                for (int i = 1; i <= 65535; i++) begin
                    @(negedge clk);
                    if (u1.u_lfsr.q == 16'h0) zero_seen = 1'b1;
                    if (i < 65535 && u1.u_lfsr.q == SEED) early++;
                end
                check("lfsr_period", u1.u_lfsr.q, SEED);
                check("lfsr_no_zero", zero_seen, 0);
                check("lfsr_no_early_return", early, 0);
            end
            begin : draw_tests
                // Full range, 16 holes: every candidate accepted in 2 cycles.
                seen = '0;
                for (int n = 0; n < 1000; n++) begin
                    start_req(1, 1'b0, 1'b0, 16'h0, 1'b1);
                    wait_result(1, 1'b0, 1'b0, 16'h0, p, lat);
                    seen[p[3:0]] = 1'b1;
                    if (n == 0) check("first_latency16", lat, 2);
                end
                check("all_16_seen", seen, 16'hFFFF);

                // Rejection, 9 holes, repeats allowed.
                reps = 0;
                prev = -1;
                for (int n = 0; n < 1000; n++) begin
                    start_req(0, 1'b0, 1'b0, 16'h0, 1'b1);
                    wait_result(0, 1'b0, 1'b0, 16'h0, p, lat);
                    check("range9", (p <= 8), 1);
                    check("lat_bound", (lat <= 9), 1);
                    if (p == prev) reps++;
                    prev = p;
                end
                check("repeats_occur", (reps > 0), 1);

                // No-repeat mode, back to back.
                for (int n = 0; n < 1000; n++) begin
                    prev = m_last[0];
                    start_req(0, 1'b1, 1'b0, 16'h0, 1'b1);
                    wait_result(0, 1'b0, 1'b0, 16'h0, p, lat);
                    check("no_repeat", (p != prev), 1);
                end

                // Fallback with a single try: low nibble F is always rejected.
                start_req(2, 1'b0, 1'b1, 16'h000F, 1'b1);
                wait_result(2, 1'b0, 1'b0, 16'h0, p, lat);
                check("fb_no_last_pos", p, 0);
                start_req(2, 1'b0, 1'b1, 16'h0008, 1'b1);
                wait_result(2, 1'b0, 1'b0, 16'h0, p, lat);
                check("fb_setup_pos8", p, 8);
                start_req(2, 1'b0, 1'b1, 16'h000F, 1'b1);
                wait_result(2, 1'b0, 1'b0, 16'h0, p, lat);
                check("fb_wrap_pos", p, 0);
                start_req(2, 1'b0, 1'b1, 16'h0003, 1'b1);
                wait_result(2, 1'b0, 1'b0, 16'h0, p, lat);
                start_req(2, 1'b0, 1'b1, 16'h000F, 1'b1);
                wait_result(2, 1'b0, 1'b0, 16'h0, p, lat);
                check("fb_incr_pos", p, 4);

                // Request while busy is dropped: exactly one pos_valid.
                start_req(0, 1'b0, 1'b0, 16'h0, 1'b1);
                wait_result(0, 1'b1, 1'b0, 16'h0, p, lat);
                extra = 0;
                repeat (12) begin
                    @(negedge clk);
                    if (pos_valid[0]) extra++;
                end
                check("busy_req_ignored", extra, 0);

                // Seed reload mid-draw: F rejected, then reloaded 5 accepted.
                start_req(0, 1'b0, 1'b1, 16'h000F, 1'b0);
                sb.push_back('{pos: 5, fb: 1'b0, lat: 3});
                wait_result(0, 1'b0, 1'b1, 16'h0005, p, lat);
                check("mid_seed_pos", p, 5);

                // Reset mid-draw: no pos_valid, outputs back to reset values.
                start_req(0, 1'b0, 1'b1, 16'h000F, 1'b0);
                @(negedge clk);
                req[0]       = 1'b0;
                seed_load[0] = 1'b0;
                check("mid_rst_busy_before", busy[0], 1);
                rst_n[0] = 1'b0;
                @(negedge clk);
                check("mid_rst_busy", busy[0], 0);
                check("mid_rst_pos", pos[0], 0);
                check("mid_rst_pos_valid", pos_valid[0], 0);
                check("mid_rst_fallback", fallback[0], 0);
                check("mid_rst_lfsr", u0.u_lfsr.q, SEED);
                rst_n[0]  = 1'b1;
                m_hl[0]   = 1'b0;
                m_last[0] = 0;
                extra = 0;
                repeat (10) begin
                    @(negedge clk);
                    if (pos_valid[0]) extra++;
                end
                check("mid_rst_no_valid", extra, 0);

                // First draw after reset cannot be a no-repeat reject.
                start_req(0, 1'b1, 1'b0, 16'h0, 1'b1);
                wait_result(0, 1'b0, 1'b0, 16'h0, p, lat);
            end
        join

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
